maze_mem_arbiter: RTL



---
 rtl/maze_mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/maze_mem_arbiter.sv
// Shares the single-port maze RAM between the host loader and the solver, with a clear sweep.
// Optional ARB_HOST_PRIO_EN: fixed host priority replaces round-robin arbitration.
module maze_mem_arbiter #(
   parameter int            AW      = 8,
   parameter int            DW      = 1,
   parameter logic [DW-1:0] CLR_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   input  logic          slv_req,
   input  logic          slv_we,
   input  logic [AW-1:0] slv_addr,
   input  logic [DW-1:0] slv_wdata,
   output logic          slv_gnt,
   output logic          slv_rvalid,
   output logic [DW-1:0] slv_rdata,
   input  logic          lock,
   input  logic          clr_start,
   output logic          clr_busy,
   output logic          clr_done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, ACC_H, ACC_S, RD_WAIT, CLEAR, CLR_END} state_t;

   localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

   state_t        state, state_nxt;
   logic [AW-1:0] cnt;
   logic          pend;
   logic          rd_slv;
   logic [DW-1:0] host_hold, slv_hold;
   logic          host_elig, slv_elig, pick_slv;

   // A host write is held off while the solver owns the maze; host reads still go through.
   assign host_elig = host_req & ~(host_we & lock);
   assign slv_elig  = slv_req;

`ifdef ARB_HOST_PRIO_EN
   assign pick_slv = slv_elig & ~host_elig;
`else
   logic rr_ptr;  // 1 = solver was granted last

   assign pick_slv = slv_elig & (~host_elig | ~rr_ptr);

   always_ff @(posedge clk) begin
      if (!rst)
         rr_ptr <= 1'b0;
      else if (state == IDLE && !pend && (host_elig || slv_elig))
         rr_ptr <= pick_slv;
   end
`endif

   always_comb begin
      state_nxt   = state;
      host_gnt    = 1'b0;
      slv_gnt     = 1'b0;
      host_rvalid = 1'b0;
      slv_rvalid  = 1'b0;
      host_rdata  = host_hold;
      slv_rdata   = slv_hold;
      clr_busy    = 1'b0;
      clr_done    = 1'b0;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_wdata   = '0;
      unique case (state)
         IDLE: begin
            if (pend)           state_nxt = CLEAR;
            else if (pick_slv)  state_nxt = ACC_S;
            else if (host_elig) state_nxt = ACC_H;
         end
         ACC_H: begin
            host_gnt  = 1'b1;
            mem_addr  = host_addr;
            mem_we    = host_we;
            mem_wdata = host_wdata;
            state_nxt = host_we ? IDLE : RD_WAIT;
         end
         ACC_S: begin
            slv_gnt   = 1'b1;
            mem_addr  = slv_addr;
            mem_we    = slv_we;
            mem_wdata = slv_wdata;
            state_nxt = slv_we ? IDLE : RD_WAIT;
         end
         RD_WAIT: begin
            if (rd_slv) begin
               slv_rvalid = 1'b1;
               slv_rdata  = mem_rdata;
            end else begin
               host_rvalid = 1'b1;
               host_rdata  = mem_rdata;
            end
            state_nxt = IDLE;
         end
         CLEAR: begin
            clr_busy  = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cnt;
            mem_wdata = CLR_VAL;
            if (&cnt) state_nxt = CLR_END;
         end
         CLR_END: begin
            clr_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         pend      <= 1'b0;
         rd_slv    <= 1'b0;
         host_hold <= '0;
         slv_hold  <= '0;
      end else begin
         state <= state_nxt;
         // IDLE with pending always enters CLEAR, which consumes it; a new pulse re-arms it.
         pend  <= clr_start | (pend & (state != IDLE));
         if (state == CLEAR)        cnt <= cnt + CNT_ONE;
         else if (state == CLR_END) cnt <= '0;
         if (state == ACC_S)        rd_slv <= 1'b1;
         else if (state == ACC_H)   rd_slv <= 1'b0;
         if (state == RD_WAIT) begin
            if (rd_slv) slv_hold  <= mem_rdata;
            else        host_hold <= mem_rdata;
         end
      end
   end

endmodule
